// File: rtl/a2_bridge_pkg.sv
// a2_bridge_pkg: sequencer state encoding and bridge select codes shared by
// the bridge scheduler and its users.
package a2_bridge_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} bridge_state_t;
  localparam logic [2:0] BRIDGE_SEL_CTRL    = 3'd0;
  localparam logic [2:0] BRIDGE_SEL_DATA    = 3'd1;
  localparam logic [2:0] BRIDGE_SEL_ADDR_LO = 3'd2;
  localparam logic [2:0] BRIDGE_SEL_ADDR_HI = 3'd3;
  localparam logic [2:0] BRIDGE_SEL_MISC    = 3'd4;
  localparam logic [2:0] BRIDGE_SEL_DIP     = 3'd5;
endpackage

// File: rtl/a2_bridge_scheduler_if.sv
// a2_bridge_scheduler_if: multiplexed 8-bit bus between the scheduler and the
// Apple II bus-bridge CPLD.
interface a2_bridge_scheduler_if;
  logic [2:0] sel;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] d_out;
  logic       d_oe;
  logic [7:0] d_in;
  modport master (output sel, rd_n, wr_n, d_out, d_oe, input d_in);
  modport slave (input sel, rd_n, wr_n, d_out, d_oe, output d_in);
endinterface

// File: rtl/a2_bridge_rr_arbiter.sv
// a2_bridge_rr_arbiter: requester 0 wins outright; the others share
// round-robin starting from ptr_i over indices 1..NUM_REQ-1.
module a2_bridge_rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [2:0]         ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [2:0]         idx_o,
  output logic               any_o
);
  logic hit;
  // Two passes give the wrap: indices at or above ptr first, then the rest.
  always_comb begin
    hit = valid_i[0];
    idx_o = 3'd0;
    for (int j = 1; j < NUM_REQ; j++)
      if (!hit && valid_i[j] && 3'(j) >= ptr_i) begin
        hit = 1'b1;
        idx_o = 3'(j);
      end
    for (int j = 1; j < NUM_REQ; j++)
      if (!hit && valid_i[j]) begin
        hit = 1'b1;
        idx_o = 3'(j);
      end
    for (int j = 0; j < NUM_REQ; j++) gnt_o[j] = hit && idx_o == 3'(j);
  end
  assign any_o = hit;
endmodule

// File: rtl/a2_bridge_scheduler.sv
// a2_bridge_scheduler: arbitrates single-byte requests onto the shared bridge
// bus and runs each as a SETUP -> STROBE -> RELEASE waveform.
module a2_bridge_scheduler
  import a2_bridge_pkg::*;
#(
  parameter int NUM_REQ       = 3,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 1
) (
  input  logic                   clk_logic,
  input  logic                   device_reset_n,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [3*NUM_REQ-1:0]   req_sel_i,
  input  logic [NUM_REQ-1:0]     req_write_i,
  input  logic [8*NUM_REQ-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]     rsp_valid_o,
  output logic [7:0]             rsp_rdata_o,
  output logic                   busy_o,
  a2_bridge_scheduler_if.master  bridge
);
  localparam logic [2:0] RR_INIT = (NUM_REQ > 1) ? 3'd1 : 3'd0;
  bridge_state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d, rr_ptr_q, rr_ptr_d, sel_q, sel_d, idx;
  logic [NUM_REQ-1:0] owner_q, owner_d, rsp_valid_q, rsp_valid_d, gnt;
  logic [7:0] d_q, d_d, rdata_q, rdata_d;
  logic write_q, write_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d, d_oe_q, d_oe_d, any;
  a2_bridge_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .valid_i(req_valid_i),
    .ptr_i  (rr_ptr_q),
    .gnt_o  (gnt),
    .idx_o  (idx),
    .any_o  (any)
  );
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    write_d = write_q;
    rr_ptr_d = rr_ptr_q;
    sel_d = sel_q;
    rd_n_d = 1'b1;
    wr_n_d = 1'b1;
    d_d = d_q;
    d_oe_d = d_oe_q;
    rsp_valid_d = '0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (any) begin
        state_d = SETUP;
        owner_d = gnt;
        for (int i = 0; i < NUM_REQ; i++)
          if (gnt[i]) begin
            write_d = req_write_i[i];
            sel_d = req_sel_i[3*i+:3];
            if (req_write_i[i]) d_d = req_wdata_i[8*i+:8];
          end
        d_oe_d = write_d;
        if (idx != 3'd0) rr_ptr_d = (idx == 3'(NUM_REQ - 1)) ? 3'd1 : idx + 3'd1;
      end
      SETUP: if (cnt_q == 3'(SETUP_CYCLES - 1)) begin
        state_d = STROBE;
        rd_n_d = write_q;
        wr_n_d = !write_q;
      end
      STROBE: if (cnt_q == 3'(STROBE_CYCLES - 1)) begin
        state_d = RELEASE;
        rsp_valid_d = owner_q;
        rdata_d = write_q ? rdata_q : bridge.d_in;
      end else begin
        rd_n_d = write_q;
        wr_n_d = !write_q;
      end
      RELEASE: begin
        state_d = IDLE;
        sel_d = BRIDGE_SEL_CTRL;
        d_oe_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d == state_q) ? cnt_q + 3'd1 : 3'd0;
  end
  always_ff @(posedge clk_logic or negedge device_reset_n)
    if (!device_reset_n) begin
      state_q <= IDLE;
      cnt_q <= 3'd0;
      owner_q <= '0;
      write_q <= 1'b0;
      rr_ptr_q <= RR_INIT;
      sel_q <= BRIDGE_SEL_CTRL;
      rd_n_q <= 1'b1;
      wr_n_q <= 1'b1;
      d_q <= 8'd0;
      d_oe_q <= 1'b0;
      rsp_valid_q <= '0;
      rdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      owner_q <= owner_d;
      write_q <= write_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q <= sel_d;
      rd_n_q <= rd_n_d;
      wr_n_q <= wr_n_d;
      d_q <= d_d;
      d_oe_q <= d_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q <= rdata_d;
    end
  assign req_ready_o = (state_q == IDLE) ? gnt : '0;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign busy_o = state_q != IDLE;
  assign bridge.sel = sel_q;
  assign bridge.rd_n = rd_n_q;
  assign bridge.wr_n = wr_n_q;
  assign bridge.d_out = d_q;
  assign bridge.d_oe = d_oe_q;
endmodule

// File: tb/tb_a2_bridge_scheduler.sv
// tb_a2_bridge_scheduler: directed vectors for the bridge scheduler, with a
// second instance using stretched SETUP/STROBE timing.
module tb_a2_bridge_scheduler;
  import a2_bridge_pkg::*;
  localparam int N = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] valid, ready, rsp, wr, keep;
  logic [3*N-1:0] sel;
  logic [8*N-1:0] wdata;
  logic [7:0] rdata;
  logic busy;
  logic [N-1:0] valid_s, ready_s, rsp_s, wr_s;
  logic [3*N-1:0] sel_s;
  logic [8*N-1:0] wdata_s;
  logic [7:0] rdata_s;
  logic busy_s;
  int n_vec = 0, n_err = 0, cyc = 0;
  a2_bridge_scheduler_if bus ();
  a2_bridge_scheduler_if bus_s ();
  a2_bridge_scheduler #(.NUM_REQ(N)) dut (
    .clk_logic(clk), .device_reset_n(rst_n), .req_valid_i(valid), .req_ready_o(ready),
    .req_sel_i(sel), .req_write_i(wr), .req_wdata_i(wdata), .rsp_valid_o(rsp),
    .rsp_rdata_o(rdata), .busy_o(busy), .bridge(bus)
  );
  a2_bridge_scheduler #(.NUM_REQ(N), .SETUP_CYCLES(3), .STROBE_CYCLES(2)) dut_s (
    .clk_logic(clk), .device_reset_n(rst_n), .req_valid_i(valid_s), .req_ready_o(ready_s),
    .req_sel_i(sel_s), .req_write_i(wr_s), .req_wdata_i(wdata_s), .rsp_valid_o(rsp_s),
    .rsp_rdata_o(rdata_s), .busy_o(busy_s), .bridge(bus_s)
  );
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  // Waits for the next ready pulse, holds valid through the accepting edge,
  // and re-raises any requester in keep once its response arrives.
  task automatic grant_next(output int g, output int at);
    g = -1;
    at = -1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (|ready) begin
        for (int i = 0; i < N; i++) if (ready[i]) g = i;
        at = cyc;
        @(posedge clk);
        #1 valid[g] = 1'b0;
        return;
      end
      @(negedge clk);
      valid = valid | (keep & rsp);
    end
  endtask
  int g, at, prev_at;
  int rr_exp [8] = '{2, 1, 2, 1, 2, 1, 2, 1};
  initial begin
    valid = '0; wr = '0; sel = '0; wdata = '0; keep = '0; bus.d_in = 8'h00;
    valid_s = '0; wr_s = '0; sel_s = '0; wdata_s = '0; bus_s.d_in = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_bus", {bus.sel, bus.rd_n, bus.wr_n, bus.d_oe}, 6'h06);
    check("rst_d", bus.d_out, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp", rsp, 3'b000);
    check("rst_rdata", rdata, 8'h00);
    check("rst_ready", ready, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);
    sel[5:3] = BRIDGE_SEL_ADDR_LO; valid[1] = 1'b1; bus.d_in = 8'hA5;
    #1 check("rd_ready", ready, 3'b010);
    @(negedge clk); valid[1] = 1'b0;
    check("rd_setup", {bus.sel, bus.rd_n, bus.wr_n, bus.d_oe}, 6'h16);
    check("rd_busy", busy, 1'b1);
    @(negedge clk);
    check("rd_strobe", {bus.sel, bus.rd_n, bus.wr_n, bus.d_oe}, 6'h12);
    @(negedge clk);
    check("rd_release", {bus.sel, bus.rd_n, bus.wr_n, bus.d_oe}, 6'h16);
    check("rd_rsp", rsp, 3'b010);
    check("rd_data", rdata, 8'hA5);
    @(negedge clk);
    check("rd_idle", {bus.sel, bus.rd_n, bus.wr_n, bus.d_oe}, 6'h06);
    check("rd_rsp_off", rsp, 3'b000);
    check("rd_busy_off", busy, 1'b0);
    sel[8:6] = BRIDGE_SEL_CTRL; wr[2] = 1'b1; wdata[23:16] = 8'hFB; valid[2] = 1'b1;
    #1 check("wr_ready", ready, 3'b100);
    @(negedge clk); valid[2] = 1'b0;
    check("wr_setup", {bus.sel, bus.rd_n, bus.wr_n, bus.d_oe}, 6'h07);
    check("wr_setup_d", bus.d_out, 8'hFB);
    @(negedge clk);
    check("wr_strobe", {bus.sel, bus.rd_n, bus.wr_n, bus.d_oe}, 6'h05);
    check("wr_strobe_d", bus.d_out, 8'hFB);
    @(negedge clk);
    check("wr_release", {bus.sel, bus.rd_n, bus.wr_n, bus.d_oe}, 6'h07);
    check("wr_rsp", rsp, 3'b100);
    check("wr_rdata_kept", rdata, 8'hA5);
    check("wr_release_d", bus.d_out, 8'hFB);
    @(negedge clk);
    check("wr_idle", {bus.sel, bus.rd_n, bus.wr_n, bus.d_oe}, 6'h06);
    check("wr_idle_d", bus.d_out, 8'hFB);
    wr[2] = 1'b0;
    sel = {3{BRIDGE_SEL_DATA}}; valid = 3'b111;
    for (int k = 0; k < 3; k++) begin
      grant_next(g, at);
      check($sformatf("pri_g%0d", k), g, k);
      if (k > 0) check($sformatf("pri_gap%0d", k), at - prev_at, 4);
      prev_at = at;
    end
    valid[1:0] = 2'b11;
    for (int k = 0; k < 2; k++) begin
      grant_next(g, at);
      check($sformatf("pri2_g%0d", k), g, k);
      check($sformatf("pri2_gap%0d", k), at - prev_at, 4);
      prev_at = at;
    end
    keep = 3'b110; valid[2] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      grant_next(g, at);
      check($sformatf("rr_g%0d", k), g, rr_exp[k]);
      if (k > 0) check($sformatf("rr_gap%0d", k), at - prev_at, 4);
      prev_at = at;
    end
    keep = '0; valid = '0;
    repeat (4) @(negedge clk);
    check("rr_idle", busy, 1'b0);
    sel_s[5:3] = BRIDGE_SEL_DIP; valid_s[1] = 1'b1; bus_s.d_in = 8'h3C;
    #1 check("str_ready", ready_s, 3'b010);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk); valid_s = '0;
      check($sformatf("str_bus%0d", k), {bus_s.sel, bus_s.rd_n, bus_s.wr_n, bus_s.d_oe},
            {(k < 7) ? BRIDGE_SEL_DIP : BRIDGE_SEL_CTRL, 1'(!(k == 4 || k == 5)), 2'b10});
      check($sformatf("str_rsp%0d", k), rsp_s, (k == 6) ? 3'b010 : 3'b000);
      check($sformatf("str_busy%0d", k), busy_s, 1'(k < 7));
      if (k >= 6) check($sformatf("str_data%0d", k), rdata_s, 8'h5A);
      if (k == 4) bus_s.d_in = 8'hC3;
      if (k == 5) bus_s.d_in = 8'h5A;
      if (k == 6) bus_s.d_in = 8'h77;
    end
    sel[2:0] = BRIDGE_SEL_ADDR_HI; wr[0] = 1'b1; wdata[7:0] = 8'h3C; valid[0] = 1'b1;
    #1 check("rst_wr_ready", ready, 3'b001);
    @(negedge clk); valid[0] = 1'b0;
    @(negedge clk);
    check("rst_wr_strobe", {bus.sel, bus.rd_n, bus.wr_n, bus.d_oe}, 6'h1D);
    #2 rst_n = 1'b0;
    #1 check("rst_async_bus", {bus.sel, bus.rd_n, bus.wr_n, bus.d_oe}, 6'h06);
    check("rst_async_busy", busy, 1'b0);
    check("rst_async_d", bus.d_out, 8'h00);
    @(negedge clk);
    check("rst_hold_rsp", rsp, 3'b000);
    rst_n = 1'b1; wr[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rst_no_rsp%0d", k), rsp, 3'b000);
    end
    sel[8:6] = BRIDGE_SEL_MISC; valid[2] = 1'b1; bus.d_in = 8'h96;
    #1 check("post_rst_ready", ready, 3'b100);
    @(negedge clk); valid[2] = 1'b0;
    check("post_rst_setup", {bus.sel, bus.rd_n, bus.wr_n, bus.d_oe}, 6'h26);
    repeat (2) @(negedge clk);
    check("post_rst_rsp", rsp, 3'b100);
    check("post_rst_data", rdata, 8'h96);
    @(negedge clk);
    check("post_rst_idle", busy, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete within 20000 time units");
    $fatal(1);
  end
endmodule
